// File: rtl/fibo_if.sv
// Bundle between the Fibonacci controller and the surrounding system / datapath.
// Handshake: start is a single-cycle request that is accepted only while the
// controller is idle (busy=0, done=0); done pulses for one cycle when F(n) is in
// R[res_addr]. There is no separate ready, so a start outside IDLE is dropped.
interface fibo_if #(
  parameter int SIZE = 4
) ();
  logic              start;
  logic [SIZE-1:0]   n;
  logic              zero_flag;
  logic              wrt_en;
  logic              load_data;
  logic [SIZE-3:0]   wrt_addr;
  logic [SIZE-3:0]   rd_addr1;
  logic [SIZE-3:0]   rd_addr2;
  logic [SIZE-2:0]   alu_opcode;
  logic [SIZE-1:0]   count;
  logic              busy;
  logic              done;
  logic [SIZE-3:0]   res_addr;
  logic              wrap_zero;

  // Controller side
  modport slave (
    input  start, n, zero_flag,
    output wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode,
           count, busy, done, res_addr, wrap_zero
  );

  // Requesting side
  modport master (
    output start, n, zero_flag,
    input  wrt_en, load_data, wrt_addr, rd_addr1, rd_addr2, alu_opcode,
           count, busy, done, res_addr, wrap_zero
  );
endinterface

// File: rtl/fibo_controller.sv
// Moore control FSM that sequences the Fibonacci datapath to compute F(n) mod 2^SIZE.
// The 4-entry register file is a rotating window: F(k) lives at address k mod 4.
// Every output is registered; each state's output values are loaded on the edge
// that enters it. o_dbg_state exposes the current state encoding.
module fibo_controller #(
  parameter int               SIZE    = 4,
  parameter logic [SIZE-2:0]  OP_LOAD = 3'b001,
  parameter logic [SIZE-2:0]  OP_ADD  = 3'b110
) (
  input  logic        clk,
  input  logic        rst,
  fibo_if.slave       bus,
  output logic [2:0]  o_dbg_state
);

  localparam int AW = SIZE - 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_RD    = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_n;     // latched index
  logic [AW-1:0]   r_p;     // address of the term being produced
  logic [SIZE-1:0] r_iter;  // ADD steps remaining, including the current one

  logic [AW-1:0]   w_p_next;
  logic [AW-1:0]   w_p_prev;

  assign w_p_next    = r_p + 1'b1;
  assign w_p_prev    = r_p - 1'b1;
  assign o_dbg_state = r_state;

  // Single state machine: next state plus the registered outputs of that state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_n            <= '0;
      r_p            <= '0;
      r_iter         <= '0;
      bus.wrt_en     <= 1'b0;
      bus.load_data  <= 1'b0;
      bus.wrt_addr   <= '0;
      bus.rd_addr1   <= '0;
      bus.rd_addr2   <= '0;
      bus.alu_opcode <= '0;
      bus.count      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.res_addr   <= '0;
      bus.wrap_zero  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state        <= S_INIT0;
            r_n            <= bus.n;
            bus.wrap_zero  <= 1'b0;
            bus.res_addr   <= '0;
            bus.busy       <= 1'b1;
            bus.wrt_en     <= 1'b1;
            bus.load_data  <= 1'b1;
            bus.wrt_addr   <= '0;
            bus.rd_addr1   <= '0;
            bus.rd_addr2   <= '0;
            bus.alu_opcode <= OP_LOAD;
            bus.count      <= '0;
          end
        end
        S_INIT0: begin
          r_state      <= S_INIT1;
          bus.wrt_addr <= AW'(1);
          bus.count    <= SIZE'(1);
        end
        S_INIT1: begin
          if (r_n < SIZE'(2)) begin
            r_state        <= S_DONE;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            bus.wrt_en     <= 1'b0;
            bus.load_data  <= 1'b0;
            bus.wrt_addr   <= '0;
            bus.alu_opcode <= '0;
            bus.count      <= '0;
            bus.res_addr   <= r_n[AW-1:0];
          end else begin
            r_state        <= S_RD;
            r_p            <= AW'(2);
            r_iter         <= r_n - 1'b1;
            bus.wrt_en     <= 1'b0;
            bus.load_data  <= 1'b0;
            bus.alu_opcode <= OP_ADD;
            bus.wrt_addr   <= AW'(2);
            bus.rd_addr1   <= AW'(1);
            bus.rd_addr2   <= AW'(0);
            bus.count      <= '0;
          end
        end
        S_RD: begin
          r_state    <= S_WB;
          bus.wrt_en <= 1'b1;
        end
        S_WB: begin
          if (bus.zero_flag) begin
            bus.wrap_zero <= 1'b1;
          end
          r_iter <= r_iter - 1'b1;
          r_p    <= w_p_next;
          if (r_iter != SIZE'(1)) begin
            r_state      <= S_RD;
            bus.wrt_en   <= 1'b0;
            bus.wrt_addr <= w_p_next;
            bus.rd_addr1 <= r_p;
            bus.rd_addr2 <= w_p_prev;
          end else begin
            r_state        <= S_DONE;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            bus.wrt_en     <= 1'b0;
            bus.load_data  <= 1'b0;
            bus.wrt_addr   <= '0;
            bus.rd_addr1   <= '0;
            bus.rd_addr2   <= '0;
            bus.alu_opcode <= '0;
            bus.count      <= '0;
            bus.res_addr   <= r_n[AW-1:0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_controller.sv
// Directed bench for fibo_controller. A small behavioural datapath (4 x 4 register
// file, adder, zero flag) closes the loop so results can be checked in R[res_addr].
module tb_fibo_controller;

  localparam int SIZE = 4;
  localparam int W    = 14;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  fibo_if #(.SIZE(SIZE)) bus_i ();

  fibo_controller #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_i.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath
  logic [SIZE-1:0] rf [4];
  logic [SIZE-1:0] alu_res;
  assign alu_res = (bus_i.alu_opcode == 3'b110) ?
                   rf[bus_i.rd_addr1] + rf[bus_i.rd_addr2] : '0;
  assign bus_i.zero_flag = (alu_res == '0);

  always @(posedge clk) begin
    if (bus_i.wrt_en) rf[bus_i.wrt_addr] <= bus_i.load_data ? bus_i.count : alu_res;
  end

  // write trace: {load, wrt_addr, rd1, rd2, op, count (load only)}
  logic [W-1:0] log_q[$];
  logic [W-1:0] exp_q[$];
  int           add_cycles;

  function automatic logic [W-1:0] mk(input logic ld, input logic [1:0] wa,
                                      input logic [1:0] r1, input logic [1:0] r2,
                                      input logic [2:0] op, input logic [3:0] cnt);
    return {ld, wa, r1, r2, op, cnt};
  endfunction

  always @(posedge clk) begin
    if (bus_i.alu_opcode == 3'b110) add_cycles <= add_cycles + 1;
    if (bus_i.wrt_en)
      log_q.push_back(mk(bus_i.load_data, bus_i.wrt_addr, bus_i.rd_addr1, bus_i.rd_addr2,
                         bus_i.alu_opcode, bus_i.load_data ? bus_i.count : 4'd0));
  end

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start a run; returns in cycle 1 (INIT0)
  task automatic launch(input logic [3:0] nv);
    bus_i.start = 1'b1;
    bus_i.n     = nv;
    log_q.delete();
    add_cycles  = 0;
    step();
    bus_i.start = 1'b0;
    bus_i.n     = 4'hf;
  endtask

  // step until done, bounded; returns cycle number in which done is high
  task automatic wait_done(input int from_cyc, output int cyc);
    cyc = from_cyc;
    while (!bus_i.done && cyc < 100) begin
      step();
      cyc++;
    end
    if (!bus_i.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [19:0] all_outs();
    return {bus_i.wrt_en, bus_i.load_data, bus_i.wrt_addr, bus_i.rd_addr1, bus_i.rd_addr2,
            bus_i.alu_opcode, bus_i.count, bus_i.busy, bus_i.done, bus_i.res_addr,
            bus_i.wrap_zero};
  endfunction

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) rf[i] = '0;
    add_cycles  = 0;
    rst         = 1'b1;
    bus_i.start = 1'b1;
    bus_i.n     = 4'd5;

    // 1. reset dominates start
    step();
    step();
    chk("rst_outs_zero", 32'(all_outs()), 32'd0);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);

    // 2. n=5 run launched by the start still held at reset release
    rst = 1'b0;
    log_q.delete();
    step();
    bus_i.start = 1'b0;
    bus_i.n     = 4'd0;
    chk("n5_init0_state", 32'(dbg_state), 32'd1);
    chk("n5_init0_busy", 32'(bus_i.busy), 32'd1);
    wait_done(1, cyc);
    chk("n5_done_cycle", 32'(cyc), 32'd11);
    chk("n5_res_addr", 32'(bus_i.res_addr), 32'd1);
    chk("n5_busy_in_done", 32'(bus_i.busy), 32'd0);
    chk("n5_result", 32'(rf[1]), 32'd5);
    exp_q = '{mk(1, 0, 0, 0, 3'b001, 0), mk(1, 1, 0, 0, 3'b001, 1),
              mk(0, 2, 1, 0, 3'b110, 0), mk(0, 3, 2, 1, 3'b110, 0),
              mk(0, 0, 3, 2, 3'b110, 0), mk(0, 1, 0, 3, 3'b110, 0)};
    chk("n5_write_count", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("n5_write_%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
    step();
    chk("n5_done_pulse", 32'(bus_i.done), 32'd0);

    // 3. n=0 and n=1: no ADD cycles
    launch(4'd0);
    wait_done(1, cyc);
    chk("n0_done_cycle", 32'(cyc), 32'd3);
    chk("n0_res_addr", 32'(bus_i.res_addr), 32'd0);
    chk("n0_result", 32'(rf[0]), 32'd0);
    chk("n0_no_add", 32'(add_cycles), 32'd0);
    step();
    launch(4'd1);
    wait_done(1, cyc);
    chk("n1_done_cycle", 32'(cyc), 32'd3);
    chk("n1_res_addr", 32'(bus_i.res_addr), 32'd1);
    chk("n1_result", 32'(rf[1]), 32'd1);
    chk("n1_no_add", 32'(add_cycles), 32'd0);
    step();

    // 4. n=7 with a stray start in cycle 4, then start coincident with done
    launch(4'd7);
    step(); step(); step();
    bus_i.start = 1'b1;
    bus_i.n     = 4'd2;
    step();
    bus_i.start = 1'b0;
    wait_done(5, cyc);
    chk("n7_done_cycle", 32'(cyc), 32'd15);
    chk("n7_res_addr", 32'(bus_i.res_addr), 32'd3);
    chk("n7_result", 32'(rf[3]), 32'd13);
    bus_i.start = 1'b1;
    bus_i.n     = 4'd1;
    step();
    chk("start_at_done_ignored", 32'(dbg_state), 32'd0);
    step();
    chk("start_after_done_taken", 32'(dbg_state), 32'd1);
    bus_i.start = 1'b0;
    wait_done(1, cyc);
    chk("n1b_done_cycle", 32'(cyc), 32'd3);
    chk("n1b_result", 32'(rf[1]), 32'd1);
    step();

    // 5. reset in the middle of a WB, then a fresh n=3 run
    launch(4'd6);
    step(); step(); step(); step(); step();
    chk("n6_cycle6_wb", 32'(dbg_state), 32'd4);
    rst = 1'b1;
    step();
    chk("midrst_outs_zero", 32'(all_outs()), 32'd0);
    chk("midrst_state_idle", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    launch(4'd3);
    wait_done(1, cyc);
    chk("n3_done_cycle", 32'(cyc), 32'd7);
    chk("n3_res_addr", 32'(bus_i.res_addr), 32'd3);
    chk("n3_result", 32'(rf[3]), 32'd2);
    chk("n3_no_wrap", 32'(bus_i.wrap_zero), 32'd0);
    step();

    // 6. n=12 wraps to zero; sticky flag cleared by the next accepted start
    launch(4'd12);
    wait_done(1, cyc);
    chk("n12_done_cycle", 32'(cyc), 32'd25);
    chk("n12_wrap_zero", 32'(bus_i.wrap_zero), 32'd1);
    chk("n12_result", 32'(rf[0]), 32'd0);
    chk("n12_res_addr", 32'(bus_i.res_addr), 32'd0);
    step();
    chk("wrap_sticky_idle", 32'(bus_i.wrap_zero), 32'd1);
    launch(4'd4);
    chk("wrap_cleared_on_start", 32'(bus_i.wrap_zero), 32'd0);
    wait_done(1, cyc);
    chk("n4_done_cycle", 32'(cyc), 32'd9);
    chk("n4_result", 32'(rf[0]), 32'd3);
    chk("n4_wrap_zero", 32'(bus_i.wrap_zero), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
